// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

    typedef enum logic [2:0] {
        S_REQ     = 3'd0,
        S_WAIT    = 3'd1,
        S_DELIVER = 3'd2,
        S_EXEC    = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    localparam logic [1:0]  NPC_SEQ          = 2'd0;
    localparam logic [1:0]  NPC_BRANCH       = 2'd1;
    localparam logic [1:0]  NPC_JALR         = 2'd2;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - imem, decode and next-pc handshake bundle of the fetch unit
interface ifu_fetch_if #(
    parameter int XLEN = 64
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            imem_resp_err;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    logic            upd_valid;
    logic [1:0]      npc_sel;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jalr_target;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
        output instr_valid, instr, instr_pc,
        input  instr_ready, upd_valid, npc_sel, branch_target, jalr_target
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
        input  instr_valid, instr, instr_pc,
        output instr_ready, upd_valid, npc_sel, branch_target, jalr_target
    );
endinterface

// File: rtl/ifu_next_pc.sv
// rtl/ifu_next_pc.sv - next-pc select and misalignment check
module ifu_next_pc
    import ifu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      npc_sel,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);
    always_comb begin
        next_pc = pc + XLEN'(4);
        case (npc_sel)
            NPC_BRANCH: next_pc = branch_target;
            NPC_JALR:   next_pc = {jalr_target[XLEN-1:1], 1'b0};
            NPC_SEQ:    next_pc = pc + XLEN'(4);
            default:    next_pc = pc + XLEN'(4);
        endcase
        misaligned = |next_pc[1:0];
    end
endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - multicycle fetch FSM: owns pc, fetches from imem, hands off to decode
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    ifu_fetch_if.master     bus,
    output logic [XLEN-1:0] pc,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_pc,
    output logic [63:0]     instret
);
    state_t          state;
    logic            req_valid;
    logic            dec_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;

    ifu_next_pc #(.XLEN(XLEN)) u_next_pc (
        .pc            (pc),
        .npc_sel       (bus.npc_sel),
        .branch_target (bus.branch_target),
        .jalr_target   (bus.jalr_target),
        .next_pc       (next_pc),
        .misaligned    (misaligned)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.instr_valid    = dec_valid;
    assign bus.instr          = instr;
    assign bus.instr_pc       = instr_pc;

    // Handshake valids are registered alongside state, so they stay low while rst is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_pc    <= RESET_PC;
            fetch_fault <= 1'b0;
            fault_pc    <= '0;
            instret     <= '0;
            req_valid   <= 1'b0;
            dec_valid   <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    req_valid <= 1'b1;
                    if (req_valid && bus.imem_req_ready) begin
                        req_valid <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        if (bus.imem_resp_err) begin
                            fetch_fault <= 1'b1;
                            fault_pc    <= pc;
                            state       <= S_FAULT;
                        end else begin
                            instr     <= bus.imem_resp_data;
                            instr_pc  <= pc;
                            dec_valid <= 1'b1;
                            state     <= S_DELIVER;
                        end
                    end
                end
                S_DELIVER: begin
                    if (bus.instr_ready) begin
                        dec_valid <= 1'b0;
                        state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (bus.upd_valid) begin
                        if (misaligned) begin
                            fetch_fault <= 1'b1;
                            fault_pc    <= next_pc;
                            state       <= S_FAULT;
                        end else begin
                            pc        <= next_pc;
                            instret   <= instret + 64'd1;
                            req_valid <= 1'b1;
                            state     <= S_REQ;
                        end
                    end
                end
                default: begin
                    req_valid <= 1'b0;
                    dec_valid <= 1'b0;
                    state     <= S_FAULT;
                end
            endcase
        end
    end
endmodule
